// File: rtl/stream_mux_arb.sv
// N:1 valid/ready stream mux with round-robin or fixed-priority arbitration,
// packet lock and a one-beat registered output stage.
module stream_mux_arb #(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned SEL_W = $clog2(N);
    localparam int unsigned IDX_W = SEL_W + 1;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] lock_q, lock_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] grant_c;
    logic [SEL_W-1:0] cand_c;
    logic [IDX_W-1:0] idx_c;
    logic             found_c;
    logic             any_valid_c;
    logic             load_c;
    logic             xfer_c;

    assign any_valid_c = |in_valid;
    assign load_c      = ~out_valid | out_ready;

    // Grant selection: locked channel, else first valid from the pointer (RR) or from 0 (FP).
    always_comb begin
        grant_c = lock_q;
        idx_c   = '0;
        cand_c  = '0;
        found_c = 1'b0;
        if (state_q == ARB) begin
            for (int unsigned off = 0; off < N; off++) begin
                if (MODE == 0) begin
                    idx_c = {1'b0, ptr_q} + IDX_W'(off);
                    if (idx_c >= IDX_W'(N)) begin
                        idx_c = idx_c - IDX_W'(N);
                    end
                end else begin
                    idx_c = IDX_W'(off);
                end
                cand_c = SEL_W'(idx_c);
                if (!found_c && in_valid[cand_c]) begin
                    found_c = 1'b1;
                    grant_c = cand_c;
                end
            end
        end
    end

    // Ready goes only to the granted channel; forced low while reset is asserted.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_c && any_valid_c) begin
            in_ready[grant_c] = 1'b1;
        end
    end

    assign xfer_c = |(in_ready & in_valid);

    // Next-state: lock on a non-last beat, release and rotate the pointer on the last beat.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        if (xfer_c) begin
            if (in_last[grant_c]) begin
                state_d = ARB;
                if (grant_c == SEL_W'(N - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_c + SEL_W'(1);
                end
            end else begin
                state_d = LOCK;
                lock_d  = grant_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            lock_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
        end
    end

    // Output register: reloads when empty or draining, holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (load_c) begin
            out_valid <= xfer_c;
            if (xfer_c) begin
                out_data <= in_data[32'(grant_c) * W +: W];
                out_last <= in_last[grant_c];
                out_sel  <= grant_c;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed testbench for stream_mux_arb: one round-robin instance and one
// fixed-priority instance sharing clock and reset.
module tb_stream_mux_arb;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_last, in_ready;
    logic [W-1:0]   out_data;
    logic           out_last, out_valid, out_ready;
    logic [1:0]     out_sel;

    logic [N*W-1:0] fp_in_data;
    logic [N-1:0]   fp_in_valid, fp_in_last, fp_in_ready;
    logic [W-1:0]   fp_out_data;
    logic           fp_out_last, fp_out_valid, fp_out_ready;
    logic [1:0]     fp_out_sel;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    stream_mux_arb #(.N(N), .W(W), .MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_arb #(.N(N), .W(W), .MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .in_data(fp_in_data), .in_valid(fp_in_valid), .in_last(fp_in_last), .in_ready(fp_in_ready),
        .out_data(fp_out_data), .out_last(fp_out_last), .out_sel(fp_out_sel),
        .out_valid(fp_out_valid), .out_ready(fp_out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [W-1:0] v);
        in_data[ch*W +: W] = v;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
        fp_in_data = '0; fp_in_valid = '0; fp_in_last = '0; fp_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        cmp_cnt++; if (out_data !== 8'h00) begin err_cnt++; $display("FAIL rst_out_data: got %h want 00", out_data); end
        cmp_cnt++; if (out_sel !== 2'd0) begin err_cnt++; $display("FAIL rst_out_sel: got %0d want 0", out_sel); end
        cmp_cnt++; if (in_ready !== 4'b0000) begin err_cnt++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'h30 + i));
        in_valid = 4'b1111; in_last = 4'b1111;
        step(); step();
        cmp_cnt++; if (out_sel !== 2'd1) begin err_cnt++; $display("FAIL rst_pre_sel: got %0d want 1", out_sel); end
        rst_n = 1'b0;
        #1;
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
        cmp_cnt++; if (out_data !== 8'h00) begin err_cnt++; $display("FAIL rst_async_data: got %h want 00", out_data); end
        cmp_cnt++; if (in_ready !== 4'b0000) begin err_cnt++; $display("FAIL rst_async_ready: got %b want 0000", in_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        cmp_cnt++; if (in_ready !== 4'b0001) begin err_cnt++; $display("FAIL rst_first_grant: got %b want 0001", in_ready); end
        step();
        cmp_cnt++; if (out_sel !== 2'd0 || out_data !== 8'h30) begin err_cnt++; $display("FAIL rst_first_beat: got sel %0d data %h want sel 0 data 30", out_sel, out_data); end
    endtask

    task automatic test_rr_single();
        logic [1:0] exp_sel;
        apply_reset();
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
        in_valid = 4'b1111; in_last = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_sel = 2'(k % 4);
            cmp_cnt++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== 8'(8'h10 + (k % 4)) || out_last !== 1'b1) begin
                err_cnt++;
                $display("FAIL rr_beat%0d: got v%b sel %0d data %h last %b want v1 sel %0d data %h last 1",
                         k, out_valid, out_sel, out_data, out_last, exp_sel, 8'(8'h10 + (k % 4)));
            end
        end
    endtask

    task automatic test_packet_lock();
        apply_reset();
        set_data(0, 8'h10); set_data(1, 8'h11); set_data(2, 8'hA0); set_data(3, 8'h13);
        in_valid = 4'b0100; in_last = 4'b0000;
        step();
        in_valid = 4'b1111; in_last = 4'b1011; set_data(2, 8'hA1);
        #1;
        cmp_cnt++; if (in_ready !== 4'b0100) begin err_cnt++; $display("FAIL lock_ready: got %b want 0100", in_ready); end
        cmp_cnt++; if (out_sel !== 2'd2 || out_data !== 8'hA0 || out_last !== 1'b0) begin err_cnt++; $display("FAIL lock_beat1: got sel %0d data %h last %b want 2 A0 0", out_sel, out_data, out_last); end
        step();
        in_last = 4'b1111; set_data(2, 8'hA2);
        cmp_cnt++; if (out_sel !== 2'd2 || out_data !== 8'hA1 || out_last !== 1'b0) begin err_cnt++; $display("FAIL lock_beat2: got sel %0d data %h last %b want 2 A1 0", out_sel, out_data, out_last); end
        step();
        in_valid = 4'b1011;
        cmp_cnt++; if (out_sel !== 2'd2 || out_data !== 8'hA2 || out_last !== 1'b1) begin err_cnt++; $display("FAIL lock_beat3: got sel %0d data %h last %b want 2 A2 1", out_sel, out_data, out_last); end
        step();
        cmp_cnt++; if (out_sel !== 2'd3 || out_data !== 8'h13) begin err_cnt++; $display("FAIL lock_after3: got sel %0d data %h want 3 13", out_sel, out_data); end
        step();
        cmp_cnt++; if (out_sel !== 2'd0 || out_data !== 8'h10) begin err_cnt++; $display("FAIL lock_after0: got sel %0d data %h want 0 10", out_sel, out_data); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_data(0, 8'h5A);
        in_valid = 4'b0001; in_last = 4'b0001;
        step();
        out_ready = 1'b0; set_data(0, 8'h6B);
        #1;
        cmp_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin err_cnt++; $display("FAIL bp_first: got v%b data %h want v1 5A", out_valid, out_data); end
        for (int c = 0; c < 5; c++) begin
            cmp_cnt++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h5A) begin
                err_cnt++;
                $display("FAIL bp_hold%0d: got ready %b v%b data %h want 0000 v1 5A", c, in_ready, out_valid, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        cmp_cnt++; if (in_ready !== 4'b0001) begin err_cnt++; $display("FAIL bp_release_ready: got %b want 0001", in_ready); end
        step();
        in_valid = 4'b0000;
        cmp_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h6B) begin err_cnt++; $display("FAIL bp_next: got v%b data %h want v1 6B", out_valid, out_data); end
        step();
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_drain: got v%b want v0", out_valid); end
    endtask

    task automatic test_fixed_prio();
        apply_reset();
        fp_in_data[1*W +: W] = 8'h21; fp_in_data[3*W +: W] = 8'h23;
        fp_in_valid = 4'b1010; fp_in_last = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            cmp_cnt++;
            if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd1 || fp_out_data !== 8'h21) begin
                err_cnt++;
                $display("FAIL fp_ch1_%0d: got v%b sel %0d data %h want v1 1 21", k, fp_out_valid, fp_out_sel, fp_out_data);
            end
        end
        fp_in_valid = 4'b1000;
        #1;
        cmp_cnt++; if (fp_in_ready !== 4'b1000) begin err_cnt++; $display("FAIL fp_ready3: got %b want 1000", fp_in_ready); end
        step();
        cmp_cnt++; if (fp_out_sel !== 2'd3 || fp_out_data !== 8'h23) begin err_cnt++; $display("FAIL fp_ch3: got sel %0d data %h want 3 23", fp_out_sel, fp_out_data); end
    endtask

    task automatic test_idle_gap();
        apply_reset();
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'h40 + i));
        in_valid = 4'b1111; in_last = 4'b1111;
        step(); step();
        in_valid = 4'b0000;
        cmp_cnt++; if (out_sel !== 2'd1) begin err_cnt++; $display("FAIL idle_pre: got sel %0d want 1", out_sel); end
        for (int c = 0; c < 3; c++) begin
            step();
            cmp_cnt++;
            if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
                err_cnt++;
                $display("FAIL idle_gap%0d: got v%b ready %b want v0 0000", c, out_valid, in_ready);
            end
        end
        in_valid = 4'b1111;
        #1;
        cmp_cnt++; if (in_ready !== 4'b0100) begin err_cnt++; $display("FAIL idle_resume_ready: got %b want 0100", in_ready); end
        step();
        cmp_cnt++; if (out_sel !== 2'd2 || out_data !== 8'h42) begin err_cnt++; $display("FAIL idle_resume2: got sel %0d data %h want 2 42", out_sel, out_data); end
        step();
        cmp_cnt++; if (out_sel !== 2'd3 || out_data !== 8'h43) begin err_cnt++; $display("FAIL idle_resume3: got sel %0d data %h want 3 43", out_sel, out_data); end
    endtask

    initial begin
        test_reset();
        test_rr_single();
        test_packet_lock();
        test_backpressure();
        test_fixed_prio();
        test_idle_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
